// File: rtl/risc_rf_pkg.sv
// Shared constants and helpers for the multi-ported RISC register file.
// Optional same-cycle write bypass on read ports: define RISC_RF_BYPASS_EN.
package risc_rf_pkg;

   localparam int unsigned DEF_DATA_W   = 16;
   localparam int unsigned DEF_NUM_REGS = 8;
   localparam int unsigned REG_ZERO     = 0;

   // Index width for a register file of num_regs entries (at least one bit).
   function automatic int unsigned addr_w(input int unsigned num_regs);
      return (num_regs > 1) ? $clog2(num_regs) : 1;
   endfunction

endpackage

// File: rtl/risc_rf_scoreboard.sv
// Pending-register tracker: one pending bit per architectural register plus a
// registered population count. Flush beats reserve, reserve beats write-clear.
module risc_rf_scoreboard
   import risc_rf_pkg::*;
#(
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned AW       = addr_w(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                we,
   input  logic [AW-1:0]       wr_addr,
   input  logic                rsv_valid,
   input  logic [AW-1:0]       rsv_addr,
   input  logic                flush,
   output logic [NUM_REGS-1:0] pend,
   output logic [AW:0]         pend_cnt
);

   localparam int unsigned CW = AW + 1;

   logic [NUM_REGS-1:0] pend_d, pend_q;
   logic [AW:0]         pend_cnt_d, pend_cnt_q;
   logic                wr_clr, rsv_set;

   assign wr_clr  = we && (wr_addr != AW'(REG_ZERO));
   assign rsv_set = rsv_valid && (rsv_addr != AW'(REG_ZERO));

   always_comb begin
      pend_d = pend_q;
      if (wr_clr) begin
         pend_d[wr_addr] = 1'b0;
      end
      if (rsv_set) begin
         pend_d[rsv_addr] = 1'b1;
      end
      if (flush) begin
         pend_d = '0;
      end
      pend_d[REG_ZERO] = 1'b0;
   end

   // Count is taken from the next-state vector so it tracks the bits exactly.
   always_comb begin
      pend_cnt_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         pend_cnt_d = pend_cnt_d + CW'(pend_d[i]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign pend     = pend_q;
   assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/risc_regfile_mp.sv
// Multi-read-port register file with hardwired-zero R0 and a pending scoreboard.
// Define RISC_RF_BYPASS_EN to forward same-cycle writeback data to read ports.
module risc_regfile_mp
   import risc_rf_pkg::*;
#(
   parameter  int unsigned DATA_W   = DEF_DATA_W,
   parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter  int unsigned NUM_RD   = 2,
   localparam int unsigned AW       = addr_w(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [AW-1:0]            wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rsv_valid,
   input  logic [AW-1:0]            rsv_addr,
   input  logic                     flush,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   output logic [AW:0]              pend_cnt
);

   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] pend;
   logic                wr_en;

   assign wr_en = we && (wr_addr != AW'(REG_ZERO));

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[wr_addr] = wr_data;
      end
      regs_d[REG_ZERO] = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   risc_rf_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .wr_addr   (wr_addr),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .flush     (flush),
      .pend      (pend),
      .pend_cnt  (pend_cnt)
   );

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = rd_addr[k*AW +: AW];
`ifdef RISC_RF_BYPASS_EN
      logic hit;
      // A forwarded value is the freshest result, so it is never reported busy.
      assign hit                        = wr_en && (ra == wr_addr);
      assign rd_data[k*DATA_W +: DATA_W] = hit ? wr_data : regs_q[ra];
      assign rd_busy[k]                 = pend[ra] & ~hit;
`else
      assign rd_data[k*DATA_W +: DATA_W] = regs_q[ra];
      assign rd_busy[k]                 = pend[ra];
`endif
   end

endmodule

// File: tb/tb_risc_regfile_mp.sv
// Scoreboard bench for risc_regfile_mp: directed scenarios plus random traffic.
module tb_risc_regfile_mp;

   localparam int DW  = 16;
   localparam int NR  = 8;
   localparam int NRD = 2;
   localparam int AW  = 3;

   logic              clk       = 1'b0;
   logic              reset     = 1'b1;
   logic              we        = 1'b0;
   logic [AW-1:0]     wr_addr   = '0;
   logic [DW-1:0]     wr_data   = '0;
   logic              rsv_valid = 1'b0;
   logic [AW-1:0]     rsv_addr  = '0;
   logic              flush     = 1'b0;
   logic [NRD*AW-1:0] rd_addr   = '0;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_busy;
   logic [AW:0]       pend_cnt;

   always #5 clk = ~clk;

   risc_regfile_mp #(
      .DATA_W   (DW),
      .NUM_REGS (NR),
      .NUM_RD   (NRD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .flush     (flush),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .pend_cnt  (pend_cnt)
   );

   typedef struct {
      logic [NRD*DW-1:0] data;
      logic [NRD-1:0]    busy;
      logic [AW:0]       cnt;
      int                id;
   } exp_t;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   step_id    = 0;

   // Reference state: architectural register values and set of pending registers.
   logic [DW-1:0] mem_m  [NR];
   bit            pend_m [NR];

   function automatic void model_clear();
      for (int i = 0; i < NR; i++) begin
         mem_m[i]  = '0;
         pend_m[i] = 1'b0;
      end
   endfunction

   function automatic int pending_count();
      int c = 0;
      for (int i = 0; i < NR; i++) if (pend_m[i]) c++;
      return c;
   endfunction

   task automatic check(input string name, input int id, input logic [31:0] act,
                        input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s at step %0d: got 0x%0h, expected 0x%0h", name, id, act, req);
      end
   endtask

   // Apply one cycle of stimulus, queue the expected response, then advance the model.
   task automatic step(input bit rst, input bit w, input int wa, input logic [DW-1:0] wd,
                       input bit rv, input int ra, input bit fl, input int r0, input int r1);
      exp_t e;
      int   rp[NRD];
      reset     = rst;
      we        = w;
      wr_addr   = AW'(wa);
      wr_data   = wd;
      rsv_valid = rv;
      rsv_addr  = AW'(ra);
      flush     = fl;
      rd_addr   = {AW'(r1), AW'(r0)};
      rp[0] = r0;
      rp[1] = r1;
      if (rst) model_clear();
      for (int k = 0; k < NRD; k++) begin
         e.data[k*DW +: DW] = mem_m[rp[k]];
         e.busy[k]          = pend_m[rp[k]];
`ifdef RISC_RF_BYPASS_EN
         if (w && wa != 0 && rp[k] == wa) begin
            e.data[k*DW +: DW] = wd;
            e.busy[k]          = 1'b0;
         end
`endif
      end
      e.cnt = (AW+1)'(pending_count());
      e.id  = step_id;
      step_id++;
      exp_q.push_back(e);
      @(posedge clk);
      if (!rst) begin
         if (w && wa != 0) begin
            mem_m[wa]  = wd;
            pend_m[wa] = 1'b0;
         end
         if (rv && ra != 0) pend_m[ra] = 1'b1;
         if (fl) for (int i = 0; i < NR; i++) pend_m[i] = 1'b0;
      end
      #1;
   endtask

   task automatic idle_read(input int r0, input int r1);
      step(1'b0, 1'b0, 0, '0, 1'b0, 0, 1'b0, r0, r1);
   endtask

   // Monitor: compare the combinational/registered outputs mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < NRD; k++) begin
               check($sformatf("rd_data[%0d]", k), e.id, 32'(rd_data[k*DW +: DW]),
                     32'(e.data[k*DW +: DW]));
               check($sformatf("rd_busy[%0d]", k), e.id, 32'(rd_busy[k]), 32'(e.busy[k]));
            end
            check("pend_cnt", e.id, 32'(pend_cnt), 32'(e.cnt));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, wa, ra, r0, r1;
      model_clear();
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0, 0, 1);
      step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0, 2, 3);

      // Write R3 then read it back.
      step(1'b0, 1'b1, 3, 16'h1234, 1'b0, 0, 1'b0, 3, 0);
      idle_read(3, 3);
      // R0 ignores writes and reservations.
      step(1'b0, 1'b1, 0, 16'hFFFF, 1'b1, 0, 1'b0, 0, 0);
      idle_read(0, 0);
      // Reserve R5, R6, then write R5.
      step(1'b0, 1'b0, 0, '0, 1'b1, 5, 1'b0, 5, 6);
      step(1'b0, 1'b0, 0, '0, 1'b1, 6, 1'b0, 5, 6);
      step(1'b0, 1'b1, 5, 16'h0555, 1'b0, 0, 1'b0, 5, 6);
      idle_read(5, 6);
      // Reserve and write R2 in the same cycle.
      step(1'b0, 1'b1, 2, 16'h00AA, 1'b1, 2, 1'b0, 2, 2);
      idle_read(2, 2);
      // Re-reserve an already pending register.
      step(1'b0, 1'b0, 0, '0, 1'b1, 2, 1'b0, 2, 6);
      // Write R4 while both ports read R4.
      step(1'b0, 1'b1, 4, 16'hBEEF, 1'b0, 0, 1'b0, 4, 4);
      idle_read(4, 4);
      // Reserve R1..R7, flush, then reset in the middle of a write.
      for (int r = 1; r < NR; r++) step(1'b0, 1'b0, 0, '0, 1'b1, r, 1'b0, r, 0);
      step(1'b0, 1'b1, 3, 16'h7777, 1'b1, 3, 1'b1, 1, 7);
      idle_read(1, 7);
      step(1'b1, 1'b1, 3, 16'h5555, 1'b1, 4, 1'b0, 3, 4);
      for (int r = 0; r < NR; r += 2) idle_read(r, r + 1);

      for (int n = 0; n < 400; n++) begin
         w  = int'($urandom_range(0, 1));
         wa = int'($urandom_range(0, NR - 1));
         ra = int'($urandom_range(0, NR - 1));
         r0 = int'($urandom_range(0, NR - 1));
         r1 = ($urandom_range(0, 3) == 0) ? r0 : int'($urandom_range(0, NR - 1));
         if ($urandom_range(0, 3) == 0) r0 = wa;
         step(($urandom_range(0, 49) == 0), w[0], wa, DW'($urandom), $urandom_range(0, 1) == 1,
              ra, ($urandom_range(0, 9) == 0), r0, r1);
      end
      idle_read(1, 2);

      for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(posedge clk);
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/risc_regfile_mp.md
RISC_REGFILE_MP -- requirements
Module: risc_regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 8, meaning register count (power of two, >=2); AW = log2(NUM_REGS).
REQ-003 The block SHALL have parameter NUM_RD, default 2, meaning number of independent read ports (1..4).
REQ-004 The block SHALL have port clk  input  1  clock, rising-edge.
REQ-005 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port we  input  1  writeback enable.
REQ-007 The block SHALL have port wr_addr  input  AW  writeback register index.
REQ-008 The block SHALL have port wr_data  input  DATA_W  writeback data.
REQ-009 The block SHALL have port rsv_valid  input  1  issue-stage reservation request.
REQ-010 The block SHALL have port rsv_addr  input  AW  register to mark pending.
REQ-011 The block SHALL have port flush  input  1  clear all pending marks.
REQ-012 The block SHALL have port rd_addr  input  NUM_RD*AW  packed read indices, port k at bits [k*AW +: AW].
REQ-013 The block SHALL have port rd_data  output  NUM_RD*DATA_W  packed read data, combinational.
REQ-014 The block SHALL have port rd_busy  output  NUM_RD  per-port pending flag, combinational.
REQ-015 The block SHALL have port pend_cnt  output  AW+1  registered count of pending registers.

Function
REQ-016 Register 0 SHALL read as zero with rd_busy 0; writes and reservations to index 0 SHALL be ignored.
REQ-017 Writes SHALL commit on the clk edge when we=1 and wr_addr!=0; a write clears that register's pending bit.
REQ-018 A reservation with rsv_valid=1 and rsv_addr!=0 SHALL set that register's pending bit on the clk edge.
REQ-019 A reservation and a write to the same register in the same cycle SHALL leave the pending bit set (reserve wins) while data is still written.
REQ-020 A reservation of an already-pending register SHALL keep it pending and leave pend_cnt unchanged.
REQ-021 flush=1 SHALL clear all pending bits on the clk edge, overriding reserve and write-clear in that cycle; data writes still commit.
REQ-022 pend_cnt SHALL equal the population count of pending bits after each edge, never exceeding NUM_REGS-1.
REQ-023 Each read port SHALL be independent; identical addresses on multiple ports SHALL return identical results.

Reset
REQ-024 Reset SHALL asynchronously clear all registers to 0, all pending bits to 0 and pend_cnt to 0.
REQ-025 Reset asserted mid-operation SHALL discard any same-cycle write or reservation.

Configuration
REQ-026 With RISC_RF_BYPASS_EN defined, a read port whose address equals wr_addr while we=1 and wr_addr!=0 SHALL return wr_data and rd_busy 0 in the same cycle.
REQ-027 Without RISC_RF_BYPASS_EN, reads SHALL return stored contents and stored pending bits only (write visible the next cycle).

Structure
REQ-028 Package risc_rf_pkg SHALL hold the default DATA_W/NUM_REGS constants, the REG_ZERO index constant and an address-width function.
REQ-029 The pending-bit array and pend_cnt SHALL live in sub-module risc_rf_scoreboard; storage and read muxing stay in the top.

Verification
REQ-030 Reset, write R3=0x1234, next cycle read port0=R3 -> rd_data 0x1234, rd_busy 0.
REQ-031 Write R0=0xFFFF, reserve R0 -> rd_data 0x0000, rd_busy 0, pend_cnt 0.
REQ-032 Reserve R5 and R6 on consecutive cycles, then write R5 -> pend_cnt 1,2,1; rd_busy(R5) drops after write.
REQ-033 Reserve R2 and write R2=0x00AA same cycle -> R2 reads 0x00AA, rd_busy 1, pend_cnt 1.
REQ-034 Write R4=0xBEEF, read R4 on both ports same cycle -> with RISC_RF_BYPASS_EN both ports 0xBEEF that cycle; without it old value that cycle, 0xBEEF next.
REQ-035 Reserve R1..R7, assert flush, then reset mid-write -> pend_cnt 7 then 0; after reset all registers read 0.
